// File: rtl/usb_link_pkg.sv
// Shared types and constants for the USB receive link controller.
package usb_link_pkg;

    typedef enum logic [1:0] {
        PID_SPECIAL = 2'b00,
        PID_TOKEN   = 2'b01,
        PID_HSK     = 2'b10,
        PID_DATA    = 2'b11
    } pid_type_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TOKEN,
        ST_HSK,
        ST_DATA,
        ST_DROP
    } state_e;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_PID     = 3'd1;
    localparam logic [2:0] ERR_TOKLEN  = 3'd2;
    localparam logic [2:0] ERR_HSKLEN  = 3'd3;
    localparam logic [2:0] ERR_CRC     = 3'd4;
    localparam logic [2:0] ERR_BABBLE  = 3'd5;
    localparam logic [2:0] ERR_TIMEOUT = 3'd6;
    localparam logic [2:0] ERR_RESYNC  = 3'd7;

    localparam logic [15:0] CRC16_POLY  = 16'hA001;
    localparam logic [15:0] CRC16_INIT  = 16'hFFFF;
    localparam logic [15:0] CRC16_RESID = 16'hB001;

    function automatic logic pid_ok(input logic [7:0] b);
        return b[7:4] == ~b[3:0];
    endfunction

    // Keeps the first error cause seen in a cycle.
    function automatic logic [2:0] err_pick(input logic [2:0] cur,
                                            input logic [2:0] nxt);
        return (cur != ERR_NONE) ? cur : nxt;
    endfunction

endpackage

// File: rtl/usb_rx_link_ctrl_if.sv
// PHY-side stream and transaction-layer report bundle of the RX link.
interface usb_rx_link_ctrl_if #(
    parameter int CNT_W = 11
);
    logic             rx_en;
    logic             rx_sop;
    logic             rx_eop;
    logic             rx_valid;
    logic [7:0]       rx_data;
    logic             rx_lt_sop_en;
    logic             rx_lt_eop_en;
    logic             rx_data_on;
    logic             rx_busy;
    logic [3:0]       pid_out;
    logic             pid_valid;
    logic [6:0]       tok_addr;
    logic [3:0]       tok_endp;
    logic             tok_valid;
    logic             hsk_valid;
    logic             data_done;
    logic [CNT_W-1:0] data_len;
    logic             crc_ok;
    logic             err;
    logic [2:0]       err_code;

    modport master (
        output rx_en, rx_sop, rx_eop, rx_valid, rx_data,
        output rx_lt_sop_en, rx_lt_eop_en,
        input  rx_data_on, rx_busy, pid_out, pid_valid,
        input  tok_addr, tok_endp, tok_valid, hsk_valid,
        input  data_done, data_len, crc_ok, err, err_code
    );

    modport slave (
        input  rx_en, rx_sop, rx_eop, rx_valid, rx_data,
        input  rx_lt_sop_en, rx_lt_eop_en,
        output rx_data_on, rx_busy, pid_out, pid_valid,
        output tok_addr, tok_endp, tok_valid, hsk_valid,
        output data_done, data_len, crc_ok, err, err_code
    );
endinterface

// File: rtl/usb_crc16_byte.sv
// One-byte step of the reflected USB CRC16, LSB of the byte first.
module usb_crc16_byte
    import usb_link_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data_in,
    output logic [15:0] crc_out
);
    logic [15:0] c;

    always_comb begin
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data_in[i]) c = (c >> 1) ^ CRC16_POLY;
            else                   c = c >> 1;
        end
        crc_out = c;
    end
endmodule

// File: rtl/usb_rx_link_ctrl.sv
// USB receive link controller: PID decode, token/handshake/data
// sequencing, CRC16 check and error reporting.
module usb_rx_link_ctrl #(
    parameter int MAX_DATA    = 1023,
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 11
) (
    input logic               clk,
    input logic               rst_n,
    usb_rx_link_ctrl_if.slave link
);
    import usb_link_pkg::*;

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0]    TO_LAST   = TW'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] BABBLE_AT = CNT_W'(MAX_DATA + 2);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO       = CNT_W'(2);

    state_e           state_q, state_d;
    logic [3:0]       pid_q, pid_d;
    logic             pid_valid_q, pid_valid_d;
    logic [6:0]       tok_addr_q, tok_addr_d;
    logic [3:0]       tok_endp_q, tok_endp_d;
    logic             endp_lo_q, endp_lo_d;
    logic             tok_valid_q, tok_valid_d;
    logic             hsk_valid_q, hsk_valid_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] data_len_q, data_len_d;
    logic             crc_ok_q, crc_ok_d;
    logic             err_q, err_d;
    logic [2:0]       err_code_q, err_code_d;
    logic             err_seen_q, err_seen_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      crc_q, crc_d;
    logic [TW-1:0]    idle_q, idle_d;
    logic             data_on_q, data_on_d;
    logic             on_dly_q;

    logic             beat, sop, eop, pid_good;
    pid_type_e        ptype;
    logic [CNT_W-1:0] cnt_inc;
    logic [15:0]      crc_nxt;
    logic             eval, new_pkt, sop_on, old_fire, new_fire;
    logic [2:0]       old_cause, new_cause;

    usb_crc16_byte u_crc (
        .crc_in  (crc_q),
        .data_in (link.rx_data),
        .crc_out (crc_nxt)
    );

    assign beat     = link.rx_valid;
    assign sop      = beat & link.rx_sop;
    assign eop      = beat & link.rx_eop;
    assign pid_good = pid_ok(link.rx_data);
    assign ptype    = pid_type_e'(link.rx_data[1:0]);
    assign cnt_inc  = cnt_q + ONE;

    always_comb begin
        state_d     = state_q;
        pid_d       = pid_q;
        tok_addr_d  = tok_addr_q;
        tok_endp_d  = tok_endp_q;
        endp_lo_d   = endp_lo_q;
        data_len_d  = data_len_q;
        crc_ok_d    = crc_ok_q;
        err_code_d  = err_code_q;
        cnt_d       = cnt_q;
        crc_d       = crc_q;
        idle_d      = '0;
        pid_valid_d = 1'b0;
        tok_valid_d = 1'b0;
        hsk_valid_d = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        old_cause   = ERR_NONE;
        new_cause   = ERR_NONE;
        new_pkt     = 1'b0;
        eval        = 1'b0;
        sop_on      = 1'b0;

        // Receive-stage pulses that disagree with our own framing.
        if (state_q == ST_DATA && link.rx_lt_eop_en && !eop)
            old_cause = err_pick(old_cause, ERR_RESYNC);
        if (state_q != ST_IDLE && link.rx_lt_sop_en &&
            !data_on_q && !on_dly_q)
            old_cause = err_pick(old_cause, ERR_RESYNC);

        if (state_q == ST_IDLE) begin
            eval = sop;
        end else if (!beat) begin
            if (idle_q == TO_LAST) begin
                old_cause = err_pick(old_cause, ERR_TIMEOUT);
                state_d   = ST_IDLE;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end else if (link.rx_sop) begin
            old_cause = err_pick(old_cause, ERR_RESYNC);
            state_d   = ST_IDLE;
            eval      = 1'b1;
        end else begin
            unique case (state_q)
                ST_TOKEN: begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == ONE) begin
                        tok_addr_d = link.rx_data[6:0];
                        endp_lo_d  = link.rx_data[7];
                        if (eop) begin
                            old_cause = err_pick(old_cause, ERR_TOKLEN);
                            state_d   = ST_IDLE;
                        end
                    end else if (cnt_inc == TWO) begin
                        tok_endp_d = {link.rx_data[2:0], endp_lo_q};
                        if (eop) begin
                            tok_valid_d = 1'b1;
                            state_d     = ST_IDLE;
                        end
                    end else begin
                        old_cause = err_pick(old_cause, ERR_TOKLEN);
                        state_d   = eop ? ST_IDLE : ST_DROP;
                    end
                end
                ST_HSK: begin
                    old_cause = err_pick(old_cause, ERR_HSKLEN);
                    state_d   = eop ? ST_IDLE : ST_DROP;
                end
                ST_DATA: begin
                    cnt_d = cnt_inc;
                    crc_d = crc_nxt;
                    if (eop) begin
                        done_d     = 1'b1;
                        state_d    = ST_IDLE;
                        crc_ok_d   = (cnt_inc >= TWO) &&
                                     (crc_nxt == CRC16_RESID);
                        data_len_d = (cnt_inc >= TWO) ? cnt_inc - TWO : '0;
                        if (!crc_ok_d)
                            old_cause = err_pick(old_cause, ERR_CRC);
                    end else if (cnt_inc > BABBLE_AT) begin
                        old_cause = err_pick(old_cause, ERR_BABBLE);
                        state_d   = ST_DROP;
                    end
                end
                ST_DROP: begin
                    if (eop) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // SOP decode, shared by IDLE and mid-packet resync.
        if (eval && link.rx_en) begin
            new_pkt = 1'b1;
            cnt_d   = '0;
            crc_d   = CRC16_INIT;
            if (!pid_good) begin
                new_cause = ERR_PID;
                state_d   = eop ? ST_IDLE : ST_DROP;
            end else begin
                if (ptype != PID_SPECIAL) begin
                    pid_d       = link.rx_data[3:0];
                    pid_valid_d = 1'b1;
                end
                unique case (ptype)
                    PID_SPECIAL: state_d = eop ? ST_IDLE : ST_DROP;
                    PID_TOKEN: begin
                        state_d = eop ? ST_IDLE : ST_TOKEN;
                        if (eop) new_cause = ERR_TOKLEN;
                    end
                    PID_HSK: begin
                        state_d     = eop ? ST_IDLE : ST_HSK;
                        hsk_valid_d = eop;
                    end
                    PID_DATA: begin
                        sop_on  = 1'b1;
                        state_d = eop ? ST_IDLE : ST_DATA;
                        if (eop) new_cause = ERR_TOKLEN;
                    end
                endcase
            end
        end

        old_fire = (old_cause != ERR_NONE) && !err_seen_q;
        new_fire = (new_cause != ERR_NONE) && !old_fire;
        err_d    = old_fire | new_fire;
        if (old_fire)      err_code_d = old_cause;
        else if (new_fire) err_code_d = new_cause;
        err_seen_d = new_pkt ? (new_cause != ERR_NONE)
                             : (err_seen_q | (old_cause != ERR_NONE));
        data_on_d  = (state_d == ST_DATA);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pid_q       <= '0;
            pid_valid_q <= 1'b0;
            tok_addr_q  <= '0;
            tok_endp_q  <= '0;
            endp_lo_q   <= 1'b0;
            tok_valid_q <= 1'b0;
            hsk_valid_q <= 1'b0;
            done_q      <= 1'b0;
            data_len_q  <= '0;
            crc_ok_q    <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= '0;
            err_seen_q  <= 1'b0;
            cnt_q       <= '0;
            crc_q       <= '0;
            idle_q      <= '0;
            data_on_q   <= 1'b0;
            on_dly_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pid_q       <= pid_d;
            pid_valid_q <= pid_valid_d;
            tok_addr_q  <= tok_addr_d;
            tok_endp_q  <= tok_endp_d;
            endp_lo_q   <= endp_lo_d;
            tok_valid_q <= tok_valid_d;
            hsk_valid_q <= hsk_valid_d;
            done_q      <= done_d;
            data_len_q  <= data_len_d;
            crc_ok_q    <= crc_ok_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            err_seen_q  <= err_seen_d;
            cnt_q       <= cnt_d;
            crc_q       <= crc_d;
            idle_q      <= idle_d;
            data_on_q   <= data_on_d;
            on_dly_q    <= data_on_q | sop_on;
        end
    end

    assign link.rx_data_on = data_on_q | sop_on;
    assign link.rx_busy    = (state_q != ST_IDLE);
    assign link.pid_out    = pid_q;
    assign link.pid_valid  = pid_valid_q;
    assign link.tok_addr   = tok_addr_q;
    assign link.tok_endp   = tok_endp_q;
    assign link.tok_valid  = tok_valid_q;
    assign link.hsk_valid  = hsk_valid_q;
    assign link.data_done  = done_q;
    assign link.data_len   = data_len_q;
    assign link.crc_ok     = crc_ok_q;
    assign link.err        = err_q;
    assign link.err_code   = err_code_q;

endmodule

// File: tb/tb_usb_rx_link_ctrl.sv
// Directed bench for usb_rx_link_ctrl with pulse-counting monitor.
module tb_usb_rx_link_ctrl;

    localparam int CNT_W = 11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    usb_rx_link_ctrl_if #(.CNT_W(CNT_W)) bus ();

    usb_rx_link_ctrl #(
        .MAX_DATA    (1023),
        .TIMEOUT_CYC (16),
        .CNT_W       (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .link  (bus)
    );

    int n_pid, n_tok, n_hsk, n_done, n_err, n_on;
    int last_code, last_len, last_crc, sop_on;
    int b_pid, b_tok, b_hsk, b_done, b_err, b_on;
    int n_chk, n_pass;

    always @(negedge clk) begin
        if (bus.pid_valid) n_pid <= n_pid + 1;
        if (bus.tok_valid) n_tok <= n_tok + 1;
        if (bus.hsk_valid) n_hsk <= n_hsk + 1;
        if (bus.rx_data_on) n_on <= n_on + 1;
        if (bus.err) begin
            n_err     <= n_err + 1;
            last_code <= int'(bus.err_code);
        end
        if (bus.data_done) begin
            n_done   <= n_done + 1;
            last_len <= int'(bus.data_len);
            last_crc <= int'(bus.crc_ok);
        end
        if (bus.rx_valid && bus.rx_sop) sop_on <= int'(bus.rx_data_on);
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic snap();
        b_pid = n_pid; b_tok = n_tok; b_hsk = n_hsk;
        b_done = n_done; b_err = n_err; b_on = n_on;
    endtask

    task automatic beat(input logic [7:0] d, input logic s, input logic e);
        bus.rx_valid = 1'b1;
        bus.rx_data  = d;
        bus.rx_sop   = s;
        bus.rx_eop   = e;
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
        bus.rx_sop   = 1'b0;
        bus.rx_eop   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pkt(input logic [7:0] q[$]);
        foreach (q[i]) beat(q[i], i == 0, i == q.size() - 1);
    endtask

    function automatic logic [15:0] crc16(input logic [7:0] q[$]);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        foreach (q[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ q[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 16'hA001;
            end
        end
        return ~c;
    endfunction

    task automatic data_pkt(input logic [7:0] pay[$], input bit flip);
        logic [7:0]  q[$];
        logic [15:0] c;
        c = crc16(pay);
        q = pay;
        if (flip) q[0] = q[0] ^ 8'h01;
        q.push_front(8'hC3);
        q.push_back(c[7:0]);
        q.push_back(c[15:8]);
        pkt(q);
    endtask

    logic [7:0] q[$];
    logic [7:0] p[$];

    initial begin
        bus.rx_en        = 1'b1;
        bus.rx_sop       = 1'b0;
        bus.rx_eop       = 1'b0;
        bus.rx_valid     = 1'b0;
        bus.rx_data      = 8'h00;
        bus.rx_lt_sop_en = 1'b0;
        bus.rx_lt_eop_en = 1'b0;
        idle(3);
        chk("rst_busy", int'(bus.rx_busy), 0);
        chk("rst_on", int'(bus.rx_data_on), 0);
        chk("rst_pid", int'(bus.pid_out), 0);
        chk("rst_addr", int'(bus.tok_addr), 0);
        chk("rst_len", int'(bus.data_len), 0);
        chk("rst_err", int'(bus.err) + int'(bus.err_code), 0);
        rst_n = 1'b1;
        idle(2);

        // SETUP addr 5 endp 5
        snap(); q = '{8'h2D, 8'h85, 8'h02}; pkt(q); idle(3);
        chk("tok_pidv", n_pid - b_pid, 1);
        chk("tok_pid", int'(bus.pid_out), 13);
        chk("tok_addr", int'(bus.tok_addr), 5);
        chk("tok_endp", int'(bus.tok_endp), 5);
        chk("tok_valid", n_tok - b_tok, 1);
        chk("tok_err", n_err - b_err, 0);
        chk("tok_busy", int'(bus.rx_busy), 0);

        // DATA0 with good CRC
        snap(); p = '{8'h00, 8'h05}; data_pkt(p, 1'b0); idle(3);
        chk("d_sop_on", sop_on, 1);
        chk("d_on_cyc", n_on - b_on, 5);
        chk("d_done", n_done - b_done, 1);
        chk("d_len", last_len, 2);
        chk("d_crc", last_crc, 1);
        chk("d_err", n_err - b_err, 0);
        chk("d_pid", int'(bus.pid_out), 3);

        // same packet, one payload bit flipped
        snap(); data_pkt(p, 1'b1); idle(3);
        chk("bad_done", n_done - b_done, 1);
        chk("bad_crc", last_crc, 0);
        chk("bad_err", n_err - b_err, 1);
        chk("bad_code", last_code, 4);

        // bad PID check, trailing bytes dropped
        snap(); q = '{8'h2E, 8'h11, 8'h22}; pkt(q); idle(3);
        chk("pid_err", n_err - b_err, 1);
        chk("pid_code", last_code, 1);
        chk("pid_on", n_on - b_on, 0);
        chk("pid_pidv", n_pid - b_pid, 0);
        chk("pid_busy", int'(bus.rx_busy), 0);

        // ACK alone, then ACK with extra byte
        snap(); q = '{8'hD2}; pkt(q); idle(3);
        chk("ack_hsk", n_hsk - b_hsk, 1);
        chk("ack_pid", int'(bus.pid_out), 2);
        chk("ack_err", n_err - b_err, 0);
        snap(); q = '{8'hD2, 8'h00}; pkt(q); idle(3);
        chk("ackx_hsk", n_hsk - b_hsk, 0);
        chk("ackx_code", last_code, 3);
        chk("ackx_err", n_err - b_err, 1);

        // token ending on byte 1
        snap(); q = '{8'h2D, 8'h85}; pkt(q); idle(3);
        chk("tok1_code", last_code, 2);
        chk("tok1_tok", n_tok - b_tok, 0);

        // timeout: 15 idle cycles survive, the 16th aborts
        snap(); beat(8'hC3, 1'b1, 1'b0); idle(15);
        chk("tmo_busy15", int'(bus.rx_busy), 1);
        chk("tmo_err15", n_err - b_err, 0);
        idle(3);
        chk("tmo_err", n_err - b_err, 1);
        chk("tmo_code", last_code, 6);
        chk("tmo_busy", int'(bus.rx_busy), 0);
        chk("tmo_done", n_done - b_done, 0);

        // longest legal payload
        snap(); p = {};
        for (int i = 0; i < 1023; i++) p.push_back(8'(i * 7));
        data_pkt(p, 1'b0); idle(3);
        chk("max_len", last_len, 1023);
        chk("max_crc", last_crc, 1);
        chk("max_err", n_err - b_err, 0);

        // babble: 1026 bytes without EOP
        snap(); beat(8'hC3, 1'b1, 1'b0);
        for (int i = 0; i < 1026; i++) beat(8'(i), 1'b0, 1'b0);
        chk("bab_on", int'(bus.rx_data_on), 0);
        chk("bab_busy", int'(bus.rx_busy), 1);
        beat(8'h00, 1'b0, 1'b1); idle(3);
        chk("bab_err", n_err - b_err, 1);
        chk("bab_code", last_code, 5);
        chk("bab_done", n_done - b_done, 0);

        // SOP in the middle of DATA, new token decoded
        snap();
        beat(8'hC3, 1'b1, 1'b0); beat(8'h00, 1'b0, 1'b0);
        beat(8'h11, 1'b0, 1'b0);
        q = '{8'h2D, 8'h0A, 8'h00}; pkt(q); idle(3);
        chk("rs_err", n_err - b_err, 1);
        chk("rs_code", last_code, 7);
        chk("rs_tok", n_tok - b_tok, 1);
        chk("rs_addr", int'(bus.tok_addr), 10);
        chk("rs_pidv", n_pid - b_pid, 2);
        chk("rs_done", n_done - b_done, 0);

        // stray receive-stage EOP, then a CRC error: one err only
        snap(); p = '{8'h00, 8'h05};
        beat(8'hC3, 1'b1, 1'b0); beat(8'h00, 1'b0, 1'b0);
        bus.rx_lt_eop_en = 1'b1; idle(1); bus.rx_lt_eop_en = 1'b0;
        beat(8'h04, 1'b0, 1'b0);
        beat(crc16(p) & 16'h00FF, 1'b0, 1'b0);
        beat(8'(crc16(p) >> 8), 1'b0, 1'b1);
        idle(3);
        chk("sy_err", n_err - b_err, 1);
        chk("sy_code", last_code, 7);
        chk("sy_done", n_done - b_done, 1);
        chk("sy_crc", last_crc, 0);

        // SOP ignored while disabled
        bus.rx_en = 1'b0;
        snap(); q = '{8'hD2}; pkt(q); idle(3);
        chk("dis_hsk", n_hsk - b_hsk, 0);
        chk("dis_pidv", n_pid - b_pid, 0);
        bus.rx_en = 1'b1;

        // reset in the middle of a DATA packet
        snap(); beat(8'hC3, 1'b1, 1'b0); beat(8'h00, 1'b0, 1'b0);
        rst_n = 1'b0; idle(1);
        chk("mrst_busy", int'(bus.rx_busy), 0);
        chk("mrst_on", int'(bus.rx_data_on), 0);
        rst_n = 1'b1; idle(3);
        chk("mrst_err", n_err - b_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
